// File: rtl/inst_mem_loader.sv
// inst_mem_loader: program store for the carbon core, filled over a byte stream.
// Optional load checksum when INST_MEM_CHECKSUM_EN is defined.
module inst_mem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int IW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] inst,
  input  logic          boot,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err
);

  localparam int CW = AW + 1;
  localparam logic [AW-1:0] AMASK = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LEN,
    S_LO,
    S_HI
`ifdef INST_MEM_CHECKSUM_EN
    ,
    S_CKSUM,
    S_ERR
`endif
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_addr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic [7:0]    r_lo;
  logic          r_done;
  logic          w_acc;
  logic          w_last;
`ifdef INST_MEM_CHECKSUM_EN
  logic [7:0]    r_ck;
`endif

  assign w_acc     = ld_valid && ld_ready;
  assign w_last    = (r_cnt + CW'(1)) == r_len;
  assign load_done = r_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (load_start) w_next = S_LEN;
        else if (boot)  w_next = S_RUN;
      end
      S_LEN: if (w_acc) w_next = S_LO;
      S_LO:  if (w_acc) w_next = S_HI;
      S_HI: begin
        if (w_acc) begin
`ifdef INST_MEM_CHECKSUM_EN
          w_next = w_last ? S_CKSUM : S_LO;
`else
          w_next = w_last ? S_RUN : S_LO;
`endif
        end
      end
`ifdef INST_MEM_CHECKSUM_EN
      S_CKSUM: begin
        if (w_acc) w_next = (ld_data == r_ck) ? S_RUN : S_ERR;
      end
      S_ERR: if (load_start) w_next = S_LEN;
`endif
      S_RUN: if (load_start) w_next = S_LEN;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    ld_ready = 1'b0;
    core_rst = 1'b1;
    inst     = '0;
    load_err = 1'b0;
    unique case (r_state)
      S_LEN, S_LO, S_HI: ld_ready = 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
      S_CKSUM: ld_ready = 1'b1;
      S_ERR:   load_err = 1'b1;
`endif
      S_RUN: begin
        core_rst = 1'b0;
        inst     = r_mem[pc & AMASK];
      end
      default: ;
    endcase
  end

  // Load bookkeeping: length, write pointer, low byte, completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
`ifdef INST_MEM_CHECKSUM_EN
      r_ck      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        unique case (r_state)
          S_LEN: begin
            r_len     <= (ld_data == 8'd0) ? CW'(DEPTH) : CW'(ld_data);
            r_wr_addr <= '0;
            r_cnt     <= '0;
`ifdef INST_MEM_CHECKSUM_EN
            r_ck      <= ld_data;
`endif
          end
          S_LO: begin
            r_lo <= ld_data;
`ifdef INST_MEM_CHECKSUM_EN
            r_ck <= r_ck ^ ld_data;
`endif
          end
          S_HI: begin
            r_wr_addr <= (r_wr_addr == AMASK) ? '0 : r_wr_addr + 1'b1;
            r_cnt     <= r_cnt + CW'(1);
`ifdef INST_MEM_CHECKSUM_EN
            r_ck      <= r_ck ^ ld_data;
`else
            r_done    <= w_last;
`endif
          end
`ifdef INST_MEM_CHECKSUM_EN
          S_CKSUM: r_done <= (ld_data == r_ck);
`endif
          default: ;
        endcase
      end
    end
  end

  // Program store write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_acc && r_state == S_HI)
      r_mem[r_wr_addr] <= IW'({ld_data[5:0], r_lo});
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: table vectors, hand sequences and randomized loads
// checked against a word-level model of the program store.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc = '0;
  logic [13:0] inst;
  logic        boot = 1'b0;
  logic        load_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready, core_rst, load_done, load_err;

  int errors = 0;
  int checks = 0;
  logic [13:0] mdl [256];
  logic [13:0] wq [$];

  typedef struct {
    logic [7:0]  lo0, hi0, lo1, hi1;
    logic [13:0] e0, e1;
  } vec_t;
  vec_t vt [4];

  inst_mem_loader #(.DEPTH(256), .AW(8), .IW(14)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .boot(boot), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int k;
    if (gap) begin
      ld_valid = 1'b0;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = b;
    k = 0;
    while (!ld_ready && k < 50) begin
      tick();
      k++;
    end
    if (ld_ready) tick();
    else chk("ready_timeout", {31'd0, ld_ready}, 1);
    ld_valid = 1'b0;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic check_pc(input int a, input string nm);
    pc = 8'(a);
    #1;
    chk(nm, {18'd0, inst}, {18'd0, mdl[a]});
  endtask

  task automatic finish_checks(input string nm);
    chk({nm, "_done"}, {31'd0, load_done}, 1);
    tick();
    chk({nm, "_done_pulse"}, {31'd0, load_done}, 0);
    chk({nm, "_core_rst"}, {31'd0, core_rst}, 0);
  endtask

  // gapmode: 0 none, 1 toggle every byte, 2 random
  task automatic do_load(input logic [7:0] n, input int gapmode,
                         input string nm);
    logic [7:0] ck, b;
    bit g;
    start_load();
    ck = n;
    send(n, 1'b0);
    foreach (wq[i]) begin
      b = wq[i][7:0];
      ck ^= b;
      g = (gapmode == 1) || (gapmode == 2 && $urandom_range(0, 1) == 1);
      send(b, g);
      b = {2'($urandom_range(0, 3)), wq[i][13:8]};
      ck ^= b;
      g = (gapmode == 1) || (gapmode == 2 && $urandom_range(0, 1) == 1);
      send(b, g);
    end
`ifdef INST_MEM_CHECKSUM_EN
    send(ck, 1'b0);
`endif
    finish_checks(nm);
    foreach (wq[i]) mdl[i % 256] = wq[i];
  endtask

  initial begin
    logic [7:0] ck;
    int n;

    vt[0] = '{8'h34, 8'h12, 8'h78, 8'hFF, 14'h1234, 14'h3F78};
    vt[1] = '{8'hAA, 8'h05, 8'h01, 8'h80, 14'h05AA, 14'h0001};
    vt[2] = '{8'h00, 8'hC0, 8'hFF, 8'h3F, 14'h0000, 14'h3FFF};
    vt[3] = '{8'h5A, 8'h7E, 8'hA5, 8'h81, 14'h3E5A, 14'h01A5};

    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_core_rst", {31'd0, core_rst}, 1);
    chk("rst_inst", {18'd0, inst}, 0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 0);
    chk("rst_load_done", {31'd0, load_done}, 0);
    chk("rst_load_err", {31'd0, load_err}, 0);

    // table vectors: pass 0 back-to-back, pass 1 with ld_valid toggling
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        start_load();
        chk("len_ready", {31'd0, ld_ready}, 1);
        chk("len_core_rst", {31'd0, core_rst}, 1);
        send(8'h02, p == 1);
        send(vt[i].lo0, p == 1);
        send(vt[i].hi0, p == 1);
        send(vt[i].lo1, p == 1);
        send(vt[i].hi1, p == 1);
`ifdef INST_MEM_CHECKSUM_EN
        ck = 8'h02 ^ vt[i].lo0 ^ vt[i].hi0 ^ vt[i].lo1 ^ vt[i].hi1;
        send(ck, 1'b0);
`endif
        finish_checks("vec");
        chk("run_ready", {31'd0, ld_ready}, 0);
        mdl[0] = vt[i].e0;
        mdl[1] = vt[i].e1;
        check_pc(1, "vec_w1");
        check_pc(0, "vec_w0");
      end
    end

    // randomized loads against the model
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 40);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(14'($urandom));
      do_load(8'(n), 2, "rnd");
      for (int i = 0; i < n; i++) check_pc(i, "rnd_word");
    end

    // N=0 fills the whole store
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(14'($urandom));
    do_load(8'h00, 0, "full");
    check_pc(255, "full_last");
    check_pc(0, "full_first");
    for (int i = 0; i < 6; i++) check_pc($urandom_range(0, 255), "full_rnd");

    // reset to IDLE, then load_start beats boot
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    boot = 1'b1;
    load_start = 1'b1;
    tick();
    boot = 1'b0;
    load_start = 1'b0;
    chk("start_wins_ready", {31'd0, ld_ready}, 1);
    chk("start_wins_core_rst", {31'd0, core_rst}, 1);

    // reset after the third byte of a 2-word load
    send(8'h02, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_core_rst", {31'd0, core_rst}, 1);
    chk("midrst_ready", {31'd0, ld_ready}, 0);
    chk("midrst_inst", {18'd0, inst}, 0);
    tick();
    rst = 1'b0;
    tick();
    boot = 1'b1;
    tick();
    boot = 1'b0;
    chk("boot_core_rst", {31'd0, core_rst}, 0);
    mdl[0] = 14'h2211;
    check_pc(0, "boot_partial_w0");
    check_pc(1, "boot_old_w1");

`ifdef INST_MEM_CHECKSUM_EN
    start_load();
    send(8'h01, 1'b0);
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    send(8'hAE, 1'b0);
    finish_checks("ck_ok");
    mdl[0] = 14'h05AA;
    check_pc(0, "ck_ok_w0");
    start_load();
    send(8'h01, 1'b0);
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    send(8'h00, 1'b0);
    chk("ck_bad_err", {31'd0, load_err}, 1);
    chk("ck_bad_core_rst", {31'd0, core_rst}, 1);
    chk("ck_bad_inst", {18'd0, inst}, 0);
    chk("ck_bad_done", {31'd0, load_done}, 0);
    tick();
    chk("ck_err_sticky", {31'd0, load_err}, 1);
    start_load();
    chk("ck_clr_err", {31'd0, load_err}, 0);
    chk("ck_clr_ready", {31'd0, ld_ready}, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
